// File: rtl/fixed_point_pkg.sv
// Shared fixed-point constants and symmetric saturation helpers.
// Helpers work on MAXW-bit signed values, so callers must keep WIDTH <= 64.
package fixed_point_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;
  localparam int MAXW      = 128;

  typedef logic signed [MAXW-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t val;
  } sat_res_t;

  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int w);
    return -sat_max(w);
  endfunction

  // Operands are sign-extended w-bit values, so the extra top bit makes
  // this the w+1-bit sum, followed by a symmetric clamp.
  function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int w);
    logic signed [MAXW:0] sum;
    logic signed [MAXW:0] mx;
    logic signed [MAXW:0] mn;
    wide_t                hi;
    wide_t                lo;
    sat_res_t             r;
    hi    = sat_max(w);
    lo    = sat_min(w);
    mx    = {hi[MAXW-1], hi};
    mn    = {lo[MAXW-1], lo};
    sum   = {a[MAXW-1], a} + {b[MAXW-1], b};
    r.sat = 1'b0;
    r.val = sum[MAXW-1:0];
    if (sum > mx) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (sum < mn) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_mul.sv
// Combinational signed Q-format multiply: full product, optional round-half-up,
// arithmetic shift by FRAC, symmetric clamp with a saturation flag.
module sat_mul
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ROUND = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] prod_o,
  output logic             sat_o
);

  localparam int PW  = 2 * WIDTH;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [PW-1:0] RND_K = (ROUND != 0 && FRAC > 0) ? (PW'(1) << RSH) : '0;
  localparam wide_t MAX_V = sat_max(WIDTH);
  localparam wide_t MIN_V = sat_min(WIDTH);

  logic signed [PW-1:0] full;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] shr;
  wide_t                ext;

  // Even MIN*MIN plus the rounding constant fits in PW bits, so no guard bit.
  always_comb begin
    full   = PW'($signed(a_i)) * PW'($signed(b_i));
    rnd    = full + $signed(RND_K);
    shr    = rnd >>> FRAC;
    ext    = wide_t'(shr);
    sat_o  = 1'b0;
    prod_o = WIDTH'(ext);
    if (ext > MAX_V) begin
      sat_o  = 1'b1;
      prod_o = WIDTH'(MAX_V);
    end else if (ext < MIN_V) begin
      sat_o  = 1'b1;
      prod_o = WIDTH'(MIN_V);
    end
  end

endmodule

// File: rtl/fixed_point_mac.sv
// Pipelined saturating fixed-point MAC summing one frame (first..last) per result;
// result valid 3 edges after the last beat; a held result stalls every stage.
module fixed_point_mac
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  logic             stall;

  logic             s1_vld_q, s1_first_q, s1_last_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;

  logic [WIDTH-1:0] mul_prod;
  logic             mul_sat;

  logic             s2_vld_q, s2_first_q, s2_last_q, s2_psat_q;
  logic [WIDTH-1:0] s2_prod_q;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic             fin_q;
  sat_res_t         add_res;

  logic             out_valid_q, out_sat_q;
  logic [WIDTH-1:0] out_data_q;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  sat_mul #(
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .ROUND(ROUND)
  ) u_sat_mul (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .prod_o(mul_prod),
    .sat_o (mul_sat)
  );

  // Without first the running sum carries on, even across a finished frame.
  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    add_res  = sat_add(wide_t'($signed(acc_q)), wide_t'($signed(s2_prod_q)), WIDTH);
    if (s2_vld_q) begin
      if (s2_first_q) begin
        acc_d    = s2_prod_q;
        sticky_d = s2_psat_q;
      end else begin
        acc_d    = WIDTH'(add_res.val);
        sticky_d = sticky_q | s2_psat_q | add_res.sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_psat_q   <= 1'b0;
      s2_prod_q   <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_first_q <= in_first;
        s1_last_q  <= in_last;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_prod_q  <= mul_prod;
        s2_psat_q  <= mul_sat;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      fin_q    <= s2_vld_q && s2_last_q;
      // Not stalled means the held result (if any) is being taken this edge.
      out_valid_q <= fin_q;
      if (fin_q) begin
        out_data_q <= acc_q;
        out_sat_q  <= sticky_q;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_mac.sv
// Self-checking bench for fixed_point_mac (Q16.16, truncating): vector table,
// latency, backpressure and mid-frame reset sequences with an output scoreboard.
module tb_fixed_point_mac;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        f;
    logic        l;
    logic [31:0] ed;
    logic        es;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_first;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  fixed_point_mac #(
    .WIDTH(32),
    .FRAC (16),
    .ROUND(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 after the beat is taken.
  task automatic send(input vec_t v);
    int   n;
    exp_t e;
    in_a     = v.a;
    in_b     = v.b;
    in_first = v.f;
    in_last  = v.l;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 for beat a=%h", v.a);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (v.l) begin
        e.d = v.ed;
        e.s = v.es;
        q.push_back(e);
      end
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got data=%h sat=%0d want none", out_data, out_sat);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sat", 32'(out_sat), 32'(e.s));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h00018000, 32'h00034000, 1'b1, 1'b1, 32'h0004E000, 1'b0};
    tbl[1]  = '{32'hFFF58000, 32'h00235000, 1'b1, 1'b1, 32'hFE8D3800, 1'b0};
    tbl[2]  = '{32'h00018000, 32'h00034000, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{32'h00052000, 32'h0006A000, 1'b0, 1'b1, 32'h0026D400, 1'b0};
    tbl[4]  = '{32'h1D4C0000, 32'h00080000, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1};
    tbl[5]  = '{32'h1D4C0000, 32'hFFF80000, 1'b1, 1'b1, 32'h80000001, 1'b1};
    tbl[6]  = '{32'h7FFF0000, 32'h00010000, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{32'h7FFF0000, 32'h00010000, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{32'hFFFF0000, 32'h00010000, 1'b0, 1'b1, 32'h7FFEFFFF, 1'b1};
    tbl[9]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1};
    tbl[10] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0};
    tbl[11] = '{32'h00000001, 32'h00000001, 1'b1, 1'b1, 32'h00000000, 1'b0};
    tbl[12] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: one-term frame taken at edge N, result visible only after N+3.
    in_a     = tbl[0].a;
    in_b     = tbl[0].b;
    in_first = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    begin
      exp_t e;
      e.d = tbl[0].ed;
      e.s = tbl[0].es;
      q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_valid_after_N+%0d", k), 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    drain("lat_drain");

    // Vector table, with random bubbles between beats.
    for (int i = 0; i < 13; i++) begin
      send(tbl[i]);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain("table_drain");

    // Back-to-back two-term frame with no gap.
    send(tbl[2]);
    send(tbl[3]);
    drain("b2b_drain");

    // Backpressure: hold the first result while more beats stream in.
    out_ready = 1'b0;
    fork
      begin
        send(tbl[0]);
        send(tbl[1]);
        send(tbl[2]);
        send(tbl[3]);
        send(tbl[4]);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (6) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
          chk("bp_hold_data", out_data, 32'h0004E000);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset after 2 of 3 beats: nothing may come out for that frame.
    send(tbl[6]);
    send(tbl[7]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstmid_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send('{32'h00034000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0});
    drain("rstmid_drain");

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
